sv_pe_multich: RTL and testbench
================================

Name: sv_pe_multich

Overview:
Parametrised multi-channel processing element for the convolution array. One ifmap stream is shared by NUM_CH filter channels. Each channel holds up to MAX_KSIZE weights locally and forms a K-tap dot product per window, adds an incoming partial sum, and emits one psum per channel. Every stage uses valid/ready handshakes, and a pipelined multiplier stalls globally under output backpressure.

Parameters:
DATA_WIDTH, 16, signed ifmap/weight width
NUM_CH, 4, filter channels sharing one ifmap sample
MAX_KSIZE, 8, maximum taps per window (power of 2 not required)
MULT_LAT, 2, multiplier pipeline depth in cycles (>=1)
ACC_W, 2*DATA_WIDTH+$clog2(MAX_KSIZE)+1, signed accumulator/psum width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  pulse; begins a job when in IDLE
kernel_size  in  $clog2(MAX_KSIZE+1)  taps per window K, sampled on start
cfg_err  out  1  one-cycle pulse: start rejected
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at job end
wgt_we  in  1  weight write strobe (honoured in IDLE only)
wgt_ch  in  $clog2(NUM_CH)  weight channel index
wgt_idx  in  $clog2(MAX_KSIZE)  tap index
wgt_data  in  DATA_WIDTH  signed weight
in_valid  in  1  ifmap beat valid
in_ready  out  1  ifmap beat accepted when in_valid&&in_ready
in_data  in  DATA_WIDTH  signed ifmap sample
in_psum  in  NUM_CH*ACC_W  per-channel ipsum; sampled on tap 0 beat only
in_last  in  1  marks final beat of the job
out_valid  out  1  psum vector valid
out_ready  in  1  downstream accepts psum vector
out_psum  out  NUM_CH*ACC_W  channel c at bits [c*ACC_W +: ACC_W]
out_sat  out  NUM_CH  per-channel saturation flags (see optional feature)

Behaviour:
- Reset values: every output is 0 and the weight file is cleared. State goes to IDLE, and the tap counter and accumulators are cleared. Reset mid-job aborts with no done pulse and discards in-flight data.
- FSM: IDLE -> RUN on start with 1<=kernel_size<=MAX_KSIZE. Latch K, clear the tap counter, clear accumulators.
- Invalid start (kernel_size 0 or >MAX_KSIZE): cfg_err pulses next cycle and the block stays IDLE.
- Start outside IDLE is ignored.
- RUN -> DRAIN on acceptance of the in_last beat.
- DRAIN -> IDLE once the multiplier pipe is empty and no output is pending. done pulses in the same cycle as the transition.
- Weight writes are ignored outside IDLE. Writes with wgt_idx >= MAX_KSIZE are ignored.
- Stall: pipe_en = !(out_valid && !out_ready). All pipeline registers, the tap counter and the accumulators hold when pipe_en = 0.
- in_ready = (state == RUN) && pipe_en.
- Per accepted beat, all channels use tap t = tap counter: prod[c] = in_data * w[c][t], a signed 2*DATA_WIDTH product.
- Products and the tap-0 ipsum travel through MULT_LAT pipeline stages together with a tap tag and a last-of-window flag.
- Accumulation at pipe exit:
  - tap 0: acc[c] = sext(prod[c]) + in_psum[c]
  - other taps: acc[c] += sext(prod[c])
  - Arithmetic wraps modulo 2^ACC_W.
- Tap counter: increments per accepted beat and wraps to 0 after K-1. For K=1 every beat is both tap 0 and the last tap of its window.
- Window complete (the tap K-1 product exits the pipe): the final acc values load into the out_psum register and out_valid rises the next cycle. out_valid holds, with data stable, until out_ready.
- Latency: last window beat accepted at cycle T -> out_valid at T+MULT_LAT+1 when there is no stall.
- Throughput: one beat per cycle while out_ready stays high.
- in_last mid-window (tap count != K-1): the partial window is flushed as a completed window and emitted normally.
- Simultaneous out_ready and a new window completion: the old vector retires and the new one loads in the same cycle, with no bubble.

Optional Feature:
PE_SAT_EN
- Defined: each emitted channel value is clamped to the signed 2*DATA_WIDTH range. The result is sign-extended to ACC_W, and out_sat[c] is set alongside the vector when clamping occurred. Accumulation itself is unchanged.
- Undefined: values pass through unclamped and out_sat is tied to 0.

Test Plan:
1. Reset while busy: rstn low for 1 cycle at any point -> busy=0, out_valid=0, no done pulse, weights read back as 0 in the next job.
2. K=3, NUM_CH=4, weights w[c]={1,2,3}*(c+1), in_data 1,2,3, in_psum[c]=10 -> out_psum[c]=10+14*(c+1), i.e. {24,38,52,66}. out_valid appears 3 cycles after the third beat (MULT_LAT=2). done follows.
3. K=1, 8 back-to-back beats with out_ready held low after the 2nd output -> in_ready drops, out_psum stays stable, and no vector is lost or duplicated once out_ready returns.
4. start with kernel_size=0 and with kernel_size=9 -> cfg_err pulse, busy stays 0. A start while busy is ignored.
5. K=4 with in_last on the 2nd beat -> one output equal to the 2-tap partial sum plus ipsum, then done.
6. Build with PE_SAT_EN: in_data=-32768, w=-32768, K=8, ipsum=0 -> out_psum[c]=2147483647 sign-extended and out_sat[c]=1. Build without the macro -> exact value 8589934592 and out_sat=0.

Source files
------------

// File: rtl/sv_pe_multich.sv
// rtl/sv_pe_multich.sv - multi-channel K-tap dot-product PE with pipelined multiply and global stall
// Define PE_SAT_EN to clamp emitted psums to the signed 2*DATA_WIDTH range.
module sv_pe_multich #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int MAX_KSIZE  = 8,
  parameter int MULT_LAT   = 2,
  parameter int ACC_W      = 2*DATA_WIDTH + $clog2(MAX_KSIZE) + 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             start,
  input  logic [$clog2(MAX_KSIZE+1)-1:0]   kernel_size,
  output logic                             cfg_err,
  output logic                             busy,
  output logic                             done,
  input  logic                             wgt_we,
  input  logic [$clog2(NUM_CH)-1:0]        wgt_ch,
  input  logic [$clog2(MAX_KSIZE)-1:0]     wgt_idx,
  input  logic [DATA_WIDTH-1:0]            wgt_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic [NUM_CH*ACC_W-1:0]          in_psum,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_CH*ACC_W-1:0]          out_psum,
  output logic [NUM_CH-1:0]                out_sat
);
  localparam int KW = $clog2(MAX_KSIZE+1);
  localparam int IW = $clog2(MAX_KSIZE);
  localparam int CW = $clog2(NUM_CH);
  localparam int PW = 2*DATA_WIDTH;
  localparam int X  = MULT_LAT - 1;
  localparam logic [KW-1:0] KMAX    = KW'(MAX_KSIZE);
  localparam logic [IW:0]   IDX_LIM = (IW+1)'(MAX_KSIZE);
  localparam logic [CW:0]   CH_LIM  = (CW+1)'(NUM_CH);
`ifdef PE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-PW+1){1'b0}}, {(PW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-PW+1){1'b1}}, {(PW-1){1'b0}}};
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t state_q, state_d;

  logic [KW-1:0]                k_q;
  logic [IW-1:0]                tap_q;
  logic                         cfg_err_q;
  logic signed [DATA_WIDTH-1:0] w_q [NUM_CH][MAX_KSIZE];

  logic [MULT_LAT-1:0]  pv_q, pfirst_q, plast_q;
  logic signed [PW-1:0] pprod_q [MULT_LAT][NUM_CH];
  logic [ACC_W-1:0]     ppsum_q [MULT_LAT][NUM_CH];

  logic signed [ACC_W-1:0] acc_q  [NUM_CH];
  logic signed [ACC_W-1:0] prod_x [NUM_CH];
  logic signed [ACC_W-1:0] acc_d  [NUM_CH];
  logic signed [ACC_W-1:0] res    [NUM_CH];
  logic [NUM_CH-1:0]       sat;

  logic                    out_valid_q;
  logic [NUM_CH*ACC_W-1:0] out_psum_q;
  logic [NUM_CH-1:0]       out_sat_q;

  logic          pipe_en, accept, cfg_ok, go, beat_first, beat_last, exit_fire;
  logic [KW-1:0] k_last;

  assign pipe_en    = !(out_valid_q && !out_ready);
  assign in_ready   = (state_q == S_RUN) && pipe_en;
  assign accept     = in_valid && in_ready;
  assign cfg_ok     = (kernel_size != '0) && (kernel_size <= KMAX);
  assign go         = (state_q == S_IDLE) && start && cfg_ok;
  assign k_last     = k_q - KW'(1);
  assign beat_first = (tap_q == '0);
  // in_last closes the window early so a partial window is still emitted
  assign beat_last  = (KW'(tap_q) == k_last) || in_last;
  assign exit_fire  = pv_q[X] && pipe_en;

  assign busy      = (state_q != S_IDLE);
  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;
  assign out_psum  = out_psum_q;
  assign out_sat   = out_sat_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  if (go) state_d = S_RUN;
      S_RUN:   if (accept && in_last) state_d = S_DRAIN;
      S_DRAIN: if (!(|pv_q) && !out_valid_q) begin
        state_d = S_IDLE;
        done    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k_q       <= '0;
      tap_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state_q == S_IDLE) && start && !cfg_ok;
      if (go) begin
        k_q   <= kernel_size;
        tap_q <= '0;
      end else if (accept) begin
        tap_q <= beat_last ? '0 : tap_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int t = 0; t < MAX_KSIZE; t++) w_q[c][t] <= '0;
    end else if ((state_q == S_IDLE) && wgt_we && ({1'b0, wgt_idx} < IDX_LIM) &&
                 ({1'b0, wgt_ch} < CH_LIM)) begin
      w_q[wgt_ch][wgt_idx] <= wgt_data;
    end
  end

  // Products, ipsum and window tags move as one bundle so they stall together
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv_q     <= '0;
      pfirst_q <= '0;
      plast_q  <= '0;
      for (int s = 0; s < MULT_LAT; s++)
        for (int c = 0; c < NUM_CH; c++) begin
          pprod_q[s][c] <= '0;
          ppsum_q[s][c] <= '0;
        end
    end else if (pipe_en) begin
      pv_q[0]     <= accept;
      pfirst_q[0] <= beat_first;
      plast_q[0]  <= beat_last;
      for (int c = 0; c < NUM_CH; c++) begin
        pprod_q[0][c] <= PW'($signed(in_data)) * PW'(w_q[c][tap_q]);
        ppsum_q[0][c] <= in_psum[c*ACC_W +: ACC_W];
      end
      for (int s = 1; s < MULT_LAT; s++) begin
        pv_q[s]     <= pv_q[s-1];
        pfirst_q[s] <= pfirst_q[s-1];
        plast_q[s]  <= plast_q[s-1];
        for (int c = 0; c < NUM_CH; c++) begin
          pprod_q[s][c] <= pprod_q[s-1][c];
          ppsum_q[s][c] <= ppsum_q[s-1][c];
        end
      end
    end
  end

  always_comb begin
    sat = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      prod_x[c] = {{(ACC_W-PW){pprod_q[X][c][PW-1]}}, pprod_q[X][c]};
      acc_d[c]  = pfirst_q[X] ? prod_x[c] + ppsum_q[X][c] : acc_q[c] + prod_x[c];
`ifdef PE_SAT_EN
      if (acc_d[c] > SAT_MAX) begin
        res[c] = SAT_MAX;
        sat[c] = 1'b1;
      end else if (acc_d[c] < SAT_MIN) begin
        res[c] = SAT_MIN;
        sat[c] = 1'b1;
      end else begin
        res[c] = acc_d[c];
      end
`else
      res[c] = acc_d[c];
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_psum_q  <= '0;
      out_sat_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
    end else begin
      if (go) begin
        for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
      end else if (exit_fire) begin
        for (int c = 0; c < NUM_CH; c++) acc_q[c] <= acc_d[c];
      end
      // exit_fire implies the held vector (if any) retires on this edge
      if (exit_fire && plast_q[X]) begin
        out_valid_q <= 1'b1;
        out_sat_q   <= sat;
        for (int c = 0; c < NUM_CH; c++) out_psum_q[c*ACC_W +: ACC_W] <= res[c];
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sv_pe_multich.sv
// tb/tb_sv_pe_multich.sv - scoreboard testbench for sv_pe_multich
`timescale 1ns/1ps
module tb_sv_pe_multich;
  localparam int DW = 16;
  localparam int NC = 4;
  localparam int MK = 8;
  localparam int ML = 2;
  localparam int AW = 2*DW + $clog2(MK) + 1;
  localparam int KW = $clog2(MK+1);
  localparam int IW = $clog2(MK);
  localparam int CW = $clog2(NC);

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic start = 1'b0;
  logic [KW-1:0] kernel_size = '0;
  logic cfg_err, busy, done;
  logic wgt_we = 1'b0;
  logic [CW-1:0] wgt_ch = '0;
  logic [IW-1:0] wgt_idx = '0;
  logic [DW-1:0] wgt_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DW-1:0] in_data = '0;
  logic [NC*AW-1:0] in_psum = '0;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [NC*AW-1:0] out_psum;
  logic [NC-1:0] out_sat;

  int n_cmp = 0, n_bad = 0, cyc = 0, n_hs = 0, n_done = 0;
  logic [NC*AW-1:0] exp_q[$];
  logic [NC-1:0] exp_sat_q[$];
  logic [NC*AW-1:0] sb_exp;
  logic [NC-1:0] sb_sat;
  longint wm [NC][MK];

  sv_pe_multich #(.DATA_WIDTH(DW), .NUM_CH(NC), .MAX_KSIZE(MK), .MULT_LAT(ML), .ACC_W(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .kernel_size(kernel_size), .cfg_err(cfg_err),
    .busy(busy), .done(done), .wgt_we(wgt_we), .wgt_ch(wgt_ch), .wgt_idx(wgt_idx),
    .wgt_data(wgt_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_psum(in_psum), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_psum(out_psum), .out_sat(out_sat));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) n_done++;
    if (rstn && out_valid && out_ready) begin
      n_hs++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got psum=%h, required no output", out_psum);
      end else begin
        sb_exp = exp_q.pop_front();
        sb_sat = exp_sat_q.pop_front();
        if (out_psum !== sb_exp) begin
          n_bad++;
          $display("FAIL sb_psum: got %h, required %h", out_psum, sb_exp);
        end
        n_cmp++;
        if (out_sat !== sb_sat) begin
          n_bad++;
          $display("FAIL sb_sat: got %b, required %b", out_sat, sb_sat);
        end
      end
    end
  end

  function automatic logic [NC*AW-1:0] rep(input longint v);
    logic [NC*AW-1:0] r;
    for (int c = 0; c < NC; c++) r[c*AW +: AW] = AW'(v);
    return r;
  endfunction

  task automatic write_w(input int c, input int t, input int v);
    logic signed [DW-1:0] sv;
    sv = DW'(v);
    wgt_we = 1'b1; wgt_ch = CW'(c); wgt_idx = IW'(t); wgt_data = sv;
    @(posedge clk); #1;
    wgt_we = 1'b0;
    wm[c][t] = longint'(sv);
  endtask

  task automatic do_start(input int k);
    kernel_size = KW'(k); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_beat(input longint d, input logic [NC*AW-1:0] ps, input logic last,
                            output int t_acc);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = DW'(d); in_psum = ps; in_last = last;
    @(negedge clk);
    while (!in_ready && n < 200) begin n++; @(negedge clk); end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    t_acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    int n;
    n = 0; seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
  endtask

  task automatic test_reset;
    #1 rstn = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    n_cmp++; if (done !== 1'b0 || cfg_err !== 1'b0) begin n_bad++; $display("FAIL rst_pulses: got done=%b cfg_err=%b, required 0 0", done, cfg_err); end
    n_cmp++; if (out_psum !== '0 || out_sat !== '0) begin n_bad++; $display("FAIL rst_out_data: got %h/%b, required 0", out_psum, out_sat); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL idle_after_rst: got busy=%b in_ready=%b, required 0 0", busy, in_ready); end
    for (int c = 0; c < NC; c++) for (int t = 0; t < MK; t++) wm[c][t] = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_k3;
    int ta, n;
    bit seen;
    logic [NC*AW-1:0] e;
    for (int c = 0; c < NC; c++) for (int t = 0; t < 3; t++) write_w(c, t, (t+1)*(c+1));
    out_ready = 1'b1;
    do_start(3);
    for (int c = 0; c < NC; c++) e[c*AW +: AW] = AW'(10 + 1*wm[c][0] + 2*wm[c][1] + 3*wm[c][2]);
    exp_q.push_back(e); exp_sat_q.push_back('0);
    n_cmp++; if (e !== {36'd66, 36'd52, 36'd38, 36'd24}) begin n_bad++; $display("FAIL k3_model: got %h, required 24/38/52/66", e); end
    drive_beat(1, rep(10), 1'b0, ta);
    drive_beat(2, rep(999), 1'b0, ta);
    drive_beat(3, rep(-5), 1'b1, ta);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin n++; @(negedge clk); end
    n_cmp++; if (cyc - ta != ML + 1) begin n_bad++; $display("FAIL k3_latency: got %0d cycles, required %0d", cyc - ta, ML + 1); end
    wait_done(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL k3_done: got no done pulse, required one"); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL k3_idle: got busy=%b done=%b, required 0 0", busy, done); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL k3_drain: got %0d pending, required 0", exp_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_cfg_err;
    int ks[2];
    int ta;
    bit seen;
    logic [NC*AW-1:0] e;
    ks[0] = 0; ks[1] = 9;
    for (int i = 0; i < 2; i++) begin
      do_start(ks[i]);
      @(negedge clk);
      n_cmp++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL cfg_err_k%0d: got cfg_err=%b busy=%b, required 1 0", ks[i], cfg_err, busy); end
      @(negedge clk);
      n_cmp++; if (cfg_err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL cfg_pulse_k%0d: got cfg_err=%b busy=%b, required 0 0", ks[i], cfg_err, busy); end
      @(posedge clk); #1;
    end
    do_start(2);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL cfg_busy: got %b, required 1", busy); end
    @(posedge clk); #1;
    do_start(5);
    do_start(0);
    wgt_we = 1'b1; wgt_ch = '0; wgt_idx = '0; wgt_data = 16'd100;
    @(posedge clk); #1; wgt_we = 1'b0;
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL cfg_busy_start: got cfg_err=%b, required 0", cfg_err); end
    for (int c = 0; c < NC; c++) e[c*AW +: AW] = AW'(7 + 1*wm[c][0] + 2*wm[c][1]);
    exp_q.push_back(e); exp_sat_q.push_back('0);
    for (int c = 0; c < NC; c++) e[c*AW +: AW] = AW'(7 + 3*wm[c][0] + 4*wm[c][1]);
    exp_q.push_back(e); exp_sat_q.push_back('0);
    drive_beat(1, rep(7), 1'b0, ta);
    drive_beat(2, rep(500), 1'b0, ta);
    drive_beat(3, rep(7), 1'b0, ta);
    drive_beat(4, rep(500), 1'b1, ta);
    wait_done(seen);
    n_cmp++; if (!seen || exp_q.size() != 0) begin n_bad++; $display("FAIL cfg_job: got done=%b pending=%0d, required 1 0", seen, exp_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int ta, n, base;
    bit seen;
    logic [NC*AW-1:0] e, ps, snap;
    for (int c = 0; c < NC; c++) write_w(c, 0, c+1);
    out_ready = 1'b1;
    do_start(1);
    base = n_hs;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < NC; c++) e[c*AW +: AW] = AW'(100*c + i + (i+1)*wm[c][0]);
      exp_q.push_back(e); exp_sat_q.push_back('0);
    end
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          for (int c = 0; c < NC; c++) ps[c*AW +: AW] = AW'(100*c + i);
          drive_beat(i+1, ps, i == 7, ta);
        end
      end
      begin
        n = 0;
        while (n_hs < base + 2 && n < 200) begin @(posedge clk); #1; n++; end
        out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin n++; @(negedge clk); end
        snap = out_psum;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
          n_cmp++; if (out_valid !== 1'b1 || out_psum !== snap) begin n_bad++; $display("FAIL stall_hold: got valid=%b psum=%h, required 1 %h", out_valid, out_psum, snap); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_done(seen);
    n_cmp++; if (!seen || exp_q.size() != 0 || n_hs != base + 8) begin n_bad++; $display("FAIL b2b_count: got done=%b pending=%0d outputs=%0d, required 1 0 8", seen, exp_q.size(), n_hs - base); end
    @(posedge clk); #1;
  endtask

  task automatic test_partial_window;
    int ta;
    bit seen;
    logic [NC*AW-1:0] e;
    for (int c = 0; c < NC; c++) for (int t = 0; t < 4; t++) write_w(c, t, c - t);
    do_start(4);
    for (int c = 0; c < NC; c++) e[c*AW +: AW] = AW'(-7 + 5*wm[c][0] - 3*wm[c][1]);
    exp_q.push_back(e); exp_sat_q.push_back('0);
    drive_beat(5, rep(-7), 1'b0, ta);
    drive_beat(-3, rep(123), 1'b1, ta);
    wait_done(seen);
    n_cmp++; if (!seen || exp_q.size() != 0) begin n_bad++; $display("FAIL partial: got done=%b pending=%0d, required 1 0", seen, exp_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_busy;
    int ta, d0;
    bit seen;
    do_start(3);
    drive_beat(4, rep(1), 1'b0, ta);
    @(negedge clk);
    rstn = 1'b0;
    d0 = n_done;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL rstbusy_state: got busy=%b valid=%b ready=%b, required 0 0 0", busy, out_valid, in_ready); end
    rstn = 1'b1;
    for (int c = 0; c < NC; c++) for (int t = 0; t < MK; t++) wm[c][t] = 0;
    repeat (4) @(negedge clk);
    n_cmp++; if (n_done != d0) begin n_bad++; $display("FAIL rstbusy_done: got %0d done pulses, required 0", n_done - d0); end
    @(posedge clk); #1;
    do_start(2);
    exp_q.push_back(rep(55)); exp_sat_q.push_back('0);
    drive_beat(9, rep(55), 1'b0, ta);
    drive_beat(11, rep(3), 1'b1, ta);
    wait_done(seen);
    n_cmp++; if (!seen || exp_q.size() != 0) begin n_bad++; $display("FAIL rstbusy_job: got done=%b pending=%0d, required 1 0", seen, exp_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation;
    int ta;
    bit seen;
    for (int c = 0; c < NC; c++) for (int t = 0; t < MK; t++) write_w(c, t, -32768);
    do_start(8);
`ifdef PE_SAT_EN
    exp_q.push_back(rep(64'sd2147483647)); exp_sat_q.push_back('1);
`else
    exp_q.push_back(rep(64'sd8589934592)); exp_sat_q.push_back('0);
`endif
    for (int i = 0; i < 8; i++) drive_beat(-32768, rep(0), i == 7, ta);
    wait_done(seen);
    n_cmp++; if (!seen || exp_q.size() != 0) begin n_bad++; $display("FAIL sat_job: got done=%b pending=%0d, required 1 0", seen, exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_basic_k3;
    test_cfg_err;
    test_back_to_back;
    test_partial_window;
    test_reset_busy;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
